route_ctrl_in: RTL and testbench
================================

Name: route_ctrl_in

Overview:
- Per-input-port route/forward controller sitting directly downstream of an input-port 8-deep x 8-bit flit FIFO in the mesh router.
- Pops flits from the FIFO one at a time and decodes head flits with XY routing.
- Requests the chosen output port from the switch allocator, then forwards the packet's flits downstream under a valid/ready handshake until the tail flit.
- Holds the route for the whole packet (wormhole).

Parameters:
- X_ID, 3'd0, router X coordinate.
- Y_ID, 3'd0, router Y coordinate.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- fifo_empty  in  1  upstream FIFO has no flit.
- fifo_rd  out  1  FIFO read strobe, one cycle per flit.
- fifo_data  in  8  FIFO registered read data; valid the cycle after fifo_rd.
- req  out  5  one-hot output-port request: [0] local, [1] east, [2] west, [3] north, [4] south.
- gnt  in  1  switch allocator grant for current req.
- out_flit  out  8  flit to crossbar.
- out_valid  out  1  out_flit valid.
- out_ready  in  1  downstream accepts flit.
- release  out  1  one-cycle pulse when tail flit accepted; frees the output port.
- err  out  1  sticky protocol-error flag.
- pkt_cnt  out  16  packets forwarded (optional feature).

Behaviour:
- Flit format: [7:6] type, where 10 = head, 00 = body, 01 = tail, 11 = head+tail (single-flit packet).
- Head flit fields: [5:3] dst_x, [2:0] dst_y.
- Reset values: all outputs 0, state IDLE, route register 0, route_valid 0, flit_reg 0.
- FSM states (registered; outputs decoded from the registered state):
  - IDLE: if !fifo_empty -> POP.
  - POP: fifo_rd=1 for exactly this cycle -> CAPT.
  - CAPT: flit_reg <= fifo_data at the exiting edge. Next state:
    - head or head+tail -> REQ; route computed from fifo_data and stored; route_valid=1.
    - body/tail with route_valid=1 -> SEND.
    - body/tail with route_valid=0 -> flit dropped, err<=1, -> IDLE.
  - REQ: req=route (one-hot, stable until grant). gnt=1 -> SEND; else stay.
  - SEND: out_valid=1, out_flit=flit_reg, held stable until out_ready.
    - On out_valid&&out_ready with tail or head+tail: release=1 next cycle (pulse), route_valid<=0, -> IDLE.
    - Otherwise -> IDLE to fetch the next flit.
- XY routing, unsigned 3-bit compares, first match wins:
  - dst_x>X_ID -> east.
  - dst_x<X_ID -> west.
  - dst_y>Y_ID -> north.
  - dst_y<Y_ID -> south.
  - else -> local.
- Head arriving while route_valid=1 (missing tail): err<=1, old route discarded without release, new head routed normally.
- gnt outside REQ is ignored. out_ready outside SEND is ignored.
- fifo_rd is never asserted while fifo_empty=1 at the IDLE decision. Never more than one read is outstanding.
- Latency: fifo_empty falling in IDLE -> out_valid for a non-head flit = 3 cycles. Head flits add REQ cycles, minimum 1.
- Throughput: at most 1 flit per 4 cycles; no pipelining across flits.
- err is cleared only by rst.
- rst mid-packet: immediate return to IDLE, route dropped, no release pulse, outputs cleared asynchronously.

Optional Feature:
- Macro ROUTE_PKT_CNT_EN.
- Defined: pkt_cnt increments by 1 on each release pulse and saturates at 16'hFFFF; reset to 0.
- Undefined: pkt_cnt tied to 16'h0000 and no counter logic is built.

Test Plan:
- X_ID=2, Y_ID=2; head 8'h9A (dst 3,2), body 8'h11, tail 8'h45 queued in FIFO; gnt one cycle after req; out_ready=1 -> req=5'b00010 (east), out_flit sequence 9A,11,45; release pulses once after 45; err=0.
- Single-flit 8'hD2 (dst 2,2) at router (2,2) -> req=5'b00001 (local); on gnt, out_flit=D2; release pulse; pkt_cnt=1 with ROUTE_PKT_CNT_EN.
- Head to dst (2,0) -> req=5'b10000 (south). Hold gnt=0 for 10 cycles -> req stable, out_valid=0, no fifo_rd.
- In SEND, out_ready=0 for 5 cycles -> out_flit/out_valid held, no fifo_rd. out_ready=1 -> advance.
- Body 8'h07 with no route held -> flit dropped, err=1, no out_valid. A following valid head is routed normally.
- rst asserted in SEND mid-packet -> all outputs 0 the same cycle, no release. After rst release, a body flit sets err=1.

Source files
------------

// File: rtl/route_ctrl_in.sv
// Input-port route/forward controller: pops flits, XY-routes head flits, forwards wormhole packets.
// Define ROUTE_PKT_CNT_EN to build the saturating forwarded-packet counter on pkt_cnt.
module route_ctrl_in #(
    parameter logic [2:0] X_ID = 3'd0,
    parameter logic [2:0] Y_ID = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    output logic        fifo_rd,
    input  logic [7:0]  fifo_data,
    output logic [4:0]  req,
    input  logic        gnt,
    output logic [7:0]  out_flit,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        port_release,   // 'release' is a reserved word in SystemVerilog
    output logic        err,
    output logic [15:0] pkt_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        CAPT,
        REQ,
        SEND
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  flit_reg;
    logic [4:0]  route;
    logic        route_valid;
    logic [4:0]  route_calc;
    logic        cap_head;
    logic        tail_accept;

    assign cap_head    = fifo_data[7];
    // flit type bit 6 marks the last flit of a packet (tail or head+tail)
    assign tail_accept = (state == SEND) && out_ready && flit_reg[6];

    always_comb begin
        route_calc = 5'b00001;
        if (fifo_data[5:3] > X_ID)
            route_calc = 5'b00010;
        else if (fifo_data[5:3] < X_ID)
            route_calc = 5'b00100;
        else if (fifo_data[2:0] > Y_ID)
            route_calc = 5'b01000;
        else if (fifo_data[2:0] < Y_ID)
            route_calc = 5'b10000;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (!fifo_empty) state_nx = POP;
            POP:  state_nx = CAPT;
            CAPT: begin
                if (cap_head)
                    state_nx = REQ;
                else if (route_valid)
                    state_nx = SEND;
                else
                    state_nx = IDLE;
            end
            REQ:  if (gnt) state_nx = SEND;
            SEND: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flit_reg     <= '0;
            route        <= '0;
            route_valid  <= 1'b0;
            err          <= 1'b0;
            port_release <= 1'b0;
        end else begin
            port_release <= tail_accept;
            if (state == CAPT) begin
                flit_reg <= fifo_data;
                if (cap_head) begin
                    // a head while a route is still open means the old tail went missing
                    if (route_valid)
                        err <= 1'b1;
                    route       <= route_calc;
                    route_valid <= 1'b1;
                end else if (!route_valid) begin
                    err <= 1'b1;
                end
            end
            if (tail_accept)
                route_valid <= 1'b0;
        end
    end

    assign fifo_rd   = (state == POP);
    assign req       = (state == REQ) ? route : '0;
    assign out_valid = (state == SEND);
    assign out_flit  = (state == SEND) ? flit_reg : '0;

`ifdef ROUTE_PKT_CNT_EN
    logic [15:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (port_release && (cnt != '1))
            cnt <= cnt + 16'd1;
    end

    assign pkt_cnt = cnt;
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_route_ctrl_in.sv
// Scoreboard bench for route_ctrl_in at router (2,2): packet-level model feeds expected queues, monitor pops.
module tb_route_ctrl_in;

    localparam logic [2:0] XI = 3'd2;
    localparam logic [2:0] YI = 3'd2;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [7:0]  fifo_data;
    logic [4:0]  req;
    logic        gnt;
    logic [7:0]  out_flit;
    logic        out_valid;
    logic        out_ready;
    logic        port_release;
    logic        err;
    logic [15:0] pkt_cnt;

    route_ctrl_in #(.X_ID(XI), .Y_ID(YI)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
        .fifo_data(fifo_data), .req(req), .gnt(gnt), .out_flit(out_flit),
        .out_valid(out_valid), .out_ready(out_ready), .port_release(port_release),
        .err(err), .pkt_cnt(pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // shared between stimulus and monitor
    logic [7:0] fq[$];
    logic [7:0] exp_flit[$];
    logic [4:0] exp_req[$];

    // stimulus-owned
    int    gnt_mode;
    int    rdy_mode;
    int    hold_mode;
    int    hold_val;
    int    probe_seq;
    int    probe_kind;
    int    probe_exp;
    int    probe_act;
    string probe_name;
    bit    m_rv;
    bit    m_err;
    int    exp_rel;

    // monitor-owned
    int n_pass;
    int n_total;
    int probe_done;
    bit pending_rel;
    int rel_seen;

    task automatic chk(input string name, input int act, input int expv);
        n_total++;
        if (act == expv)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    // monitor: models the FIFO, drives gnt/out_ready, scores every handshake
    initial begin
        n_pass = 0; n_total = 0; probe_done = 0; pending_rel = 0; rel_seen = 0;
        gnt = 1'b0; out_ready = 1'b0; fifo_data = '0; fifo_empty = 1'b1;
        forever begin
            @(negedge clk);
            if (probe_done != probe_seq) begin
                int a;
                case (probe_kind)
                    1: a = (fifo_rd || req != 0 || out_flit != 0 || out_valid ||
                            port_release || err || pkt_cnt != 0) ? 1 : 0;
                    2: a = int'(err);
                    3: a = int'(pkt_cnt);
                    4: a = rel_seen;
                    default: a = probe_act;
                endcase
                chk(probe_name, a, probe_exp);
                probe_done = probe_seq;
            end
            if (rst) begin
                gnt = 1'b0;
                out_ready = 1'b0;
                pending_rel = 1'b0;
                rel_seen = 0;
            end else begin
                if (fifo_rd) begin
                    chk("fifo_rd_nonempty", int'(fq.size() > 0), 1);
                    if (fq.size() > 0)
                        fifo_data = fq.pop_front();
                end
                case (hold_mode)
                    1: begin
                        chk("gnt_hold_req", int'(req), hold_val);
                        chk("gnt_hold_valid", int'(out_valid), 0);
                        chk("gnt_hold_rd", int'(fifo_rd), 0);
                    end
                    2: begin
                        chk("rdy_hold_flit", int'(out_flit), hold_val);
                        chk("rdy_hold_valid", int'(out_valid), 1);
                        chk("rdy_hold_rd", int'(fifo_rd), 0);
                    end
                    3: begin
                        chk("drop_no_valid", int'(out_valid), 0);
                        chk("drop_no_req", int'(req), 0);
                    end
                    default: ;
                endcase
                if (port_release || pending_rel)
                    chk("release", int'(port_release), int'(pending_rel));
                if (port_release)
                    rel_seen++;
                pending_rel = 1'b0;

                case (gnt_mode)
                    1: gnt = (req != 0);
                    2: gnt = ($urandom_range(0, 2) == 0);
                    default: gnt = 1'b0;
                endcase
                case (rdy_mode)
                    1: out_ready = 1'b1;
                    2: out_ready = 1'($urandom_range(0, 1));
                    default: out_ready = 1'b0;
                endcase

                if (gnt && req != 0) begin
                    if (exp_req.size() == 0)
                        chk("req_unexpected", int'(req), 0);
                    else
                        chk("req", int'(req), int'(exp_req.pop_front()));
                end
                if (out_valid && out_ready) begin
                    if (exp_flit.size() == 0) begin
                        chk("flit_unexpected", int'(out_flit), 0);
                    end else begin
                        logic [7:0] e;
                        e = exp_flit.pop_front();
                        chk("out_flit", int'(out_flit), int'(e));
                        pending_rel = e[6];
                    end
                end
            end
            fifo_empty = (fq.size() == 0);
        end
    end

    // reference model: packet rules applied to each flit as it is queued
    function automatic logic [4:0] xy_port(input logic [7:0] f);
        int dx;
        int dy;
        dx = int'(f[5:3]) - int'(XI);
        dy = int'(f[2:0]) - int'(YI);
        if (dx > 0) return 5'b00010;
        if (dx < 0) return 5'b00100;
        if (dy > 0) return 5'b01000;
        if (dy < 0) return 5'b10000;
        return 5'b00001;
    endfunction

    function automatic int pkt_exp();
`ifdef ROUTE_PKT_CNT_EN
        return (exp_rel > 65535) ? 65535 : exp_rel;
`else
        return 0;
`endif
    endfunction

    task automatic model_flit(input logic [7:0] f);
        if (f[7]) begin
            if (m_rv) m_err = 1'b1;
            exp_req.push_back(xy_port(f));
            exp_flit.push_back(f);
            m_rv = !f[6];
            if (f[6]) exp_rel++;
        end else if (m_rv) begin
            exp_flit.push_back(f);
            if (f[6]) begin
                m_rv = 1'b0;
                exp_rel++;
            end
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string name, input int kind, input int expv, input int actv);
        probe_name = name;
        probe_kind = kind;
        probe_exp  = expv;
        probe_act  = actv;
        probe_seq++;
        repeat (2) tick();
    endtask

    task automatic push(input logic [7:0] f);
        for (int i = 0; i < 200 && fq.size() >= 8; i++) tick();
        fq.push_back(f);
        model_flit(f);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (fq.size() != 0 || exp_flit.size() != 0 || exp_req.size() != 0); i++)
            tick();
        if (fq.size() != 0 || exp_flit.size() != 0 || exp_req.size() != 0)
            probe("drain_timeout", 0, 1, 0);
        repeat (4) tick();
    endtask

    task automatic model_reset();
        fq.delete();
        exp_flit.delete();
        exp_req.delete();
        m_rv = 1'b0;
        m_err = 1'b0;
        exp_rel = 0;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int lat;
        int len;
        logic [5:0] d;
        rst = 1'b1;
        gnt_mode = 1; rdy_mode = 1; hold_mode = 0; hold_val = 0;
        probe_seq = 0; probe_kind = 0; probe_exp = 0; probe_act = 0; probe_name = "";
        model_reset();
        repeat (3) tick();
        probe("reset_outputs", 1, 0, 0);
        rst = 1'b0;
        tick();

        // three-flit packet heading east
        push(8'h9A); push(8'h11); push(8'h45);
        drain();
        probe("err_clean", 2, int'(m_err), 0);
        probe("release_count_1", 4, exp_rel, 0);
        probe("pkt_cnt_1", 3, pkt_exp(), 0);

        // single-flit local packet
        push(8'hD2);
        drain();
        probe("pkt_cnt_2", 3, pkt_exp(), 0);

        // south-bound head with grant withheld for 10 cycles
        gnt_mode = 0;
        push(8'h90); push(8'h22); push(8'h41);
        for (int i = 0; i < 50 && req == 0; i++) tick();
        if (req == 0) probe("timeout_req", 0, 1, 0);
        hold_val = 32'h10;
        hold_mode = 1;
        repeat (10) tick();
        hold_mode = 0;
        gnt_mode = 1;
        drain();

        // downstream stall for 5 cycles in SEND
        rdy_mode = 0;
        push(8'h9B); push(8'h33); push(8'h5C);
        for (int i = 0; i < 50 && !out_valid; i++) tick();
        if (!out_valid) probe("timeout_valid", 0, 1, 0);
        hold_val = 32'h9B;
        hold_mode = 2;
        repeat (5) tick();
        hold_mode = 0;
        rdy_mode = 1;
        drain();

        // idle-to-valid latency of a body flit on an open route
        push(8'h80);
        drain();
        push(8'h15);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        probe("body_latency", 0, 3, lat);
        push(8'h7F);
        drain();
        probe("release_count_2", 4, exp_rel, 0);

        // stray body with no route is dropped, then a clean packet
        do_reset();
        push(8'h07);
        hold_mode = 3;
        repeat (6) tick();
        hold_mode = 0;
        probe("err_drop", 2, int'(m_err), 0);
        push(8'hAA); push(8'h40);
        drain();
        probe("release_after_drop", 4, exp_rel, 0);
        probe("err_sticky", 2, int'(m_err), 0);

        // randomized traffic, including stray bodies and missing tails
        do_reset();
        gnt_mode = 2;
        rdy_mode = 2;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 4);
            d = 6'($urandom);
            if ($urandom_range(0, 9) == 0)
                push({2'b00, 6'($urandom)});
            if (len == 1) begin
                push({2'b11, d});
            end else begin
                push({2'b10, d});
                for (int k = 1; k < len - 1; k++)
                    push({2'b00, 6'($urandom)});
                if ($urandom_range(0, 7) != 0)
                    push({2'b01, 6'($urandom)});
            end
        end
        drain();
        gnt_mode = 1;
        rdy_mode = 1;
        probe("err_random", 2, int'(m_err), 0);
        probe("release_random", 4, exp_rel, 0);
        probe("pkt_cnt_random", 3, pkt_exp(), 0);

        // reset in the middle of a packet
        do_reset();
        rdy_mode = 0;
        push(8'hA4); push(8'h12);
        for (int i = 0; i < 50 && !out_valid; i++) tick();
        if (!out_valid) probe("timeout_valid_rst", 0, 1, 0);
        #1 rst = 1'b1;
        model_reset();
        probe("reset_midpacket", 1, 0, 0);
        rst = 1'b0;
        rdy_mode = 1;
        tick();
        push(8'h12);
        hold_mode = 3;
        repeat (6) tick();
        hold_mode = 0;
        probe("err_after_rst", 2, int'(m_err), 0);
        probe("no_release_after_rst", 4, exp_rel, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
